// File: rtl/uart_tx.sv
// uart_tx: byte-wide 8N1-style serial transmitter.
// Valid/ready byte input, one registered serial output pin.
module uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);

  localparam int CNT_W =
    (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(CLKS_PER_BIT - 1);
  localparam bit HAS_PAR  = (PARITY != 0);
  localparam bit TWO_STOP = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             stop_q, stop_d;
  logic [7:0]       data_q, data_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             rdy_q, rdy_d;

  logic tc;
  logic par_bit;

  assign tc      = (cnt_q == CNT_LAST);
  assign par_bit = (PARITY == 1) ? ~^data_q : ^data_q;

  // Next-state, bit timer and registered-output logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    data_d  = data_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    rdy_d   = rdy_q;
    cnt_d   = (state_q == S_IDLE || tc) ?
              '0 : cnt_q + CNT_W'(1);
    unique case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        rdy_d  = 1'b1;
        if (rdy_q && tx_valid) begin
          data_d  = tx_data;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          rdy_d   = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tc) begin
          state_d = S_DATA;
          idx_d   = 3'd0;
          tx_d    = data_q[0];
        end
      end
      S_DATA: begin
        if (tc) begin
          if (idx_q == 3'd7) begin
            if (HAS_PAR) begin
              state_d = S_PAR;
              tx_d    = par_bit;
            end else begin
              state_d = S_STOP;
              stop_d  = 1'b0;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = data_q[idx_q + 3'd1];
          end
        end
      end
      S_PAR: begin
        if (tc) begin
          state_d = S_STOP;
          stop_d  = 1'b0;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (tc) begin
          if (!TWO_STOP || stop_q) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            rdy_d   = 1'b1;
            tx_d    = 1'b1;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        rdy_d   = 1'b0;
      end
    endcase
  end

  // State register; reset aborts any frame and idles the line
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      stop_q  <= 1'b0;
      data_q  <= 8'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign tx_ready = rdy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx.
// Four instances cover parity/stop/baud variants.
module tb_uart_tx;

  localparam int CPB [4] = '{4, 4, 4, 434};
  localparam int PARM[4] = '{0, 2, 1, 0};
  localparam int STP [4] = '{1, 2, 2, 1};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       valid[4];
  logic       rdy[4];
  logic       txl[4];
  logic       bsy[4];

  int checks = 0;
  int errors = 0;

  logic cap_tx[$];
  logic cap_bsy[$];
  logic cap_rdy[$];

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u0 (
    .CLOCK_50(clk), .reset(rst_n), .tx_data(tx_data),
    .tx_valid(valid[0]), .tx_ready(rdy[0]),
    .tx(txl[0]), .busy(bsy[0]));

  uart_tx #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(2)) u1 (
    .CLOCK_50(clk), .reset(rst_n), .tx_data(tx_data),
    .tx_valid(valid[1]), .tx_ready(rdy[1]),
    .tx(txl[1]), .busy(bsy[1]));

  uart_tx #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(2)) u2 (
    .CLOCK_50(clk), .reset(rst_n), .tx_data(tx_data),
    .tx_valid(valid[2]), .tx_ready(rdy[2]),
    .tx(txl[2]), .busy(bsy[2]));

  uart_tx u3 (
    .CLOCK_50(clk), .reset(rst_n), .tx_data(tx_data),
    .tx_valid(valid[3]), .tx_ready(rdy[3]),
    .tx(txl[3]), .busy(bsy[3]));

  // frame length in cycles: start + 8 data + parity + stops
  function automatic int flen(int d);
    int nb;
    nb = 10 + STP[d] - 1;
    if (PARM[d] != 0) nb = nb + 1;
    return nb * CPB[d];
  endfunction

  // level of serial bit k of a frame carrying byte b
  function automatic logic model_bit(
    logic [7:0] b, int d, int k);
    int ones;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == 9 && PARM[d] != 0) begin
      ones = $countones(b);
      if (PARM[d] == 2) return (ones % 2) == 1;
      return (ones % 2) == 0;
    end
    return 1'b1;
  endfunction

  // expected line level c cycles after the first start cycle
  function automatic logic exp_tx(
    logic [7:0] b, int d, int c);
    if (c < 0 || c >= flen(d)) return 1'b1;
    return model_bit(b, d, c / CPB[d]);
  endfunction

  task automatic clear_cap();
    cap_tx.delete();
    cap_bsy.delete();
    cap_rdy.delete();
  endtask

  task automatic capture(int d, int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cap_tx.push_back(txl[d]);
      cap_bsy.push_back(bsy[d]);
      cap_rdy.push_back(rdy[d]);
    end
  endtask

  // wait for ready, present byte, return just after acceptance
  task automatic launch(int d, logic [7:0] b, bit hold);
    int t;
    t = 0;
    @(negedge clk);
    while (rdy[d] !== 1'b1 && t < 6000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 6000) begin
      checks++;
      errors++;
      $display("FAIL launch_timeout dut%0d ready=%b required 1",
               d, rdy[d]);
    end
    tx_data  = b;
    valid[d] = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) valid[d] = 1'b0;
    clear_cap();
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    valid[0] = 1'b1;
    tx_data  = 8'h5A;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      checks += 3;
      if (txl[d] !== 1'b1) begin
        errors++;
        $display("FAIL rst_tx dut%0d got %b want 1", d, txl[d]);
      end
      if (bsy[d] !== 1'b0) begin
        errors++;
        $display("FAIL rst_busy dut%0d got %b want 0", d, bsy[d]);
      end
      if (rdy[d] !== 1'b0) begin
        errors++;
        $display("FAIL rst_rdy dut%0d got %b want 0", d, rdy[d]);
      end
    end
    valid[0] = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      checks += 2;
      if (rdy[d] !== 1'b1) begin
        errors++;
        $display("FAIL rel_rdy dut%0d got %b want 1", d, rdy[d]);
      end
      if (bsy[d] !== 1'b0) begin
        errors++;
        $display("FAIL rel_busy dut%0d got %b want 0", d, bsy[d]);
      end
    end
  endtask

  task automatic test_basic();
    logic [7:0] b;
    int L, et, eb, er, first;
    L = flen(0);
    for (int n = 0; n < 4; n++) begin
      b = (n == 0) ? 8'h55 : 8'($urandom);
      launch(0, b, 1'b0);
      capture(0, L + 1);
      et = 0; eb = 0; er = 0; first = -1;
      for (int c = 0; c <= L; c++) begin
        if (cap_tx[c] !== exp_tx(b, 0, c)) begin
          et++;
          if (first < 0) first = c;
        end
        if (cap_bsy[c] !== (c < L)) eb++;
        if (cap_rdy[c] !== (c == L)) er++;
      end
      checks += 3;
      if (et != 0) begin
        errors++;
        $display("FAIL basic_tx byte=%h bad_cycles=%0d want 0 first=%0d",
                 b, et, first);
      end
      if (eb != 0) begin
        errors++;
        $display("FAIL basic_busy byte=%h bad_cycles=%0d want 0",
                 b, eb);
      end
      if (er != 0) begin
        errors++;
        $display("FAIL basic_rdy byte=%h bad_cycles=%0d want 0",
                 b, er);
      end
    end
  endtask

  task automatic test_data_latch();
    logic [7:0] b;
    int L, et;
    L = flen(0);
    for (int n = 0; n < 2; n++) begin
      b = (n == 0) ? 8'hA3 : 8'($urandom);
      launch(0, b, 1'b0);
      tx_data = (n == 0) ? 8'hFF : ~b;
      capture(0, L + 1);
      et = 0;
      for (int c = 0; c <= L; c++)
        if (cap_tx[c] !== exp_tx(b, 0, c)) et++;
      checks++;
      if (et != 0) begin
        errors++;
        $display("FAIL latch_tx byte=%h bad_cycles=%0d want 0",
                 b, et);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b1, b2;
    logic et_w, eb_w, er_w;
    int L, et, eb, er, pulses;
    L = flen(0);
    for (int n = 0; n < 2; n++) begin
      b1 = (n == 0) ? 8'h00 : 8'($urandom);
      b2 = (n == 0) ? 8'hFF : 8'($urandom);
      launch(0, b1, 1'b1);
      tx_data = b2;
      capture(0, L + 5);
      valid[0] = 1'b0;
      capture(0, L + 1);
      et = 0; eb = 0; er = 0; pulses = 0;
      for (int c = 0; c < 2 * L + 6; c++) begin
        if (c < L) begin
          et_w = exp_tx(b1, 0, c);
        end else begin
          et_w = exp_tx(b2, 0, c - L - 1);
        end
        eb_w = (c < L) || (c > L && c <= 2 * L);
        er_w = (c == L) || (c > 2 * L);
        if (cap_tx[c] !== et_w) et++;
        if (cap_bsy[c] !== eb_w) eb++;
        if (cap_rdy[c] !== er_w) er++;
        if (c <= 2 * L && cap_rdy[c] === 1'b1) pulses++;
      end
      checks += 4;
      if (et != 0) begin
        errors++;
        $display("FAIL b2b_tx %h,%h bad_cycles=%0d want 0",
                 b1, b2, et);
      end
      if (eb != 0) begin
        errors++;
        $display("FAIL b2b_busy %h,%h bad_cycles=%0d want 0",
                 b1, b2, eb);
      end
      if (er != 0) begin
        errors++;
        $display("FAIL b2b_rdy %h,%h bad_cycles=%0d want 0",
                 b1, b2, er);
      end
      if (pulses != 1) begin
        errors++;
        $display("FAIL b2b_gap ready_cycles=%0d want 1", pulses);
      end
    end
  endtask

  task automatic test_parity();
    logic [7:0] b;
    logic pw;
    int L, et, eb;
    for (int d = 1; d <= 2; d++) begin
      L = flen(d);
      for (int n = 0; n < 3; n++) begin
        b = (n == 0) ? 8'h07 : 8'($urandom);
        launch(d, b, 1'b0);
        capture(d, L + 1);
        et = 0; eb = 0;
        for (int c = 0; c <= L; c++) begin
          if (cap_tx[c] !== exp_tx(b, d, c)) et++;
          if (cap_bsy[c] !== (c < L)) eb++;
        end
        checks += 2;
        if (et != 0) begin
          errors++;
          $display("FAIL par_tx dut%0d byte=%h bad_cycles=%0d want 0",
                   d, b, et);
        end
        if (eb != 0) begin
          errors++;
          $display("FAIL par_busy dut%0d byte=%h bad_cycles=%0d want 0",
                   d, b, eb);
        end
        if (n == 0) begin
          pw = (d == 1) ? 1'b1 : 1'b0;
          checks++;
          if (cap_tx[36] !== pw) begin
            errors++;
            $display("FAIL par_bit_07 dut%0d got %b want %b",
                     d, cap_tx[36], pw);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    int L, et;
    L = flen(0);
    for (int n = 0; n < 2; n++) begin
      b = (n == 0) ? 8'h0F : (8'($urandom) & 8'hF7);
      launch(0, b, 1'b0);
      capture(0, 17);
      checks++;
      if (cap_tx[16] !== b[3]) begin
        errors++;
        $display("FAIL mid_bit3 byte=%h got %b want %b",
                 b, cap_tx[16], b[3]);
      end
      rst_n = 1'b0;
      @(negedge clk);
      checks += 3;
      if (txl[0] !== 1'b1) begin
        errors++;
        $display("FAIL abort_tx got %b want 1", txl[0]);
      end
      if (bsy[0] !== 1'b0) begin
        errors++;
        $display("FAIL abort_busy got %b want 0", bsy[0]);
      end
      if (rdy[0] !== 1'b0) begin
        errors++;
        $display("FAIL abort_rdy got %b want 0", rdy[0]);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (rdy[0] !== 1'b1) begin
        errors++;
        $display("FAIL abort_rel_rdy got %b want 1", rdy[0]);
      end
      b = (n == 0) ? 8'h81 : 8'($urandom);
      launch(0, b, 1'b0);
      capture(0, L + 1);
      et = 0;
      for (int c = 0; c <= L; c++)
        if (cap_tx[c] !== exp_tx(b, 0, c)) et++;
      checks++;
      if (et != 0) begin
        errors++;
        $display("FAIL post_abort_tx byte=%h bad_cycles=%0d want 0",
                 b, et);
      end
    end
  endtask

  task automatic test_ignore_busy();
    logic [7:0] b;
    int L, et, eb, w;
    L = flen(3);
    b = 8'($urandom) | 8'h01;
    launch(3, b, 1'b0);
    fork
      capture(3, L + 600);
      begin
        repeat (1000) @(negedge clk);
        tx_data  = ~b;
        valid[3] = 1'b1;
        repeat (5) @(negedge clk);
        valid[3] = 1'b0;
        repeat (L - 1020) @(negedge clk);
        valid[3] = 1'b1;
        repeat (3) @(negedge clk);
        valid[3] = 1'b0;
      end
    join
    et = 0; eb = 0; w = 0;
    for (int c = 0; c < L + 600; c++) begin
      if (cap_tx[c] !== exp_tx(b, 3, c)) et++;
      if (cap_bsy[c] !== (c < L)) eb++;
    end
    while (w < L && cap_tx[w] === 1'b0) w++;
    checks += 3;
    if (et != 0) begin
      errors++;
      $display("FAIL busy_ign_tx byte=%h bad_cycles=%0d want 0",
               b, et);
    end
    if (eb != 0) begin
      errors++;
      $display("FAIL busy_ign_busy bad_cycles=%0d want 0", eb);
    end
    if (w != CPB[3]) begin
      errors++;
      $display("FAIL bit_width got %0d want %0d", w, CPB[3]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    tx_data = 8'h00;
    for (int i = 0; i < 4; i++) valid[i] = 1'b0;
    test_reset();
    test_basic();
    test_data_latch();
    test_back_to_back();
    test_parity();
    test_reset_mid_frame();
    test_ignore_busy();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Byte-wide asynchronous serial transmitter.
- Converts a valid/ready byte stream into an 8N1-style frame on one output pin, e.g. a GPIO_2 header pin.
- Outbound counterpart of the push-button sampling/edge-detect logic: drives a slow external signal from the CLOCK_50 domain instead of sampling one.
- Sits between user logic (e.g. an edge-detect pulse loading a byte) and the board header.

Parameters:
CLKS_PER_BIT, 434, CLOCK_50 cycles per serial bit (434 = 115200 baud at 50 MHz); legal range 2..65535.
PARITY, 0, 0 = none, 1 = odd, 2 = even; other values illegal.
STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
CLOCK_50  input  1  system clock; all logic on its rising edge.
reset  input  1  synchronous, active-low reset (0 = reset).
tx_data  input  8  byte to send; sampled only on acceptance.
tx_valid  input  1  producer has a byte on tx_data.
tx_ready  output  1  transmitter can accept a byte this cycle.
tx  output  1  serial line; idle/mark = 1.
busy  output  1  frame in progress (START through last STOP).

Behaviour:
- Interface decided: one clock, CLOCK_50; reset is synchronous and active-low, port named reset.
- Reset values (sampled while reset==0 at a CLOCK_50 edge):
  - tx=1, tx_ready=0, busy=0, state=IDLE, counters=0.
  - Reset mid-frame aborts the frame; tx returns to 1 at that edge. No partial bits are completed.
- All outputs are registered.
- After reset deasserts: tx_ready=1 from the first edge with reset==1.
- Handshake:
  - Byte accepted at a rising edge where tx_valid && tx_ready.
  - tx_data is latched into a shift register at that edge; later changes to tx_data are ignored.
  - tx_valid while tx_ready==0 is ignored; no queuing, no error flag.
  - tx_valid may drop without acceptance with no effect.
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: tx=1, tx_ready=1, busy=0. On acceptance, the same edge sets tx=0, tx_ready=0, busy=1, state=START.
  - START: tx=0 for exactly CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held exactly CLKS_PER_BIT cycles. A 3-bit index counts 0..7.
  - PARITY: present only if PARITY!=0; one bit time.
    - Odd: tx = ~^data. Even: tx = ^data. Computed on the latched byte.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - After the last STOP cycle, the next edge sets state=IDLE, busy=0, tx_ready=1.
- Bit timer:
  - Width ceil(log2(CLKS_PER_BIT)) bits; counts 0..CLKS_PER_BIT-1.
  - Advances the bit at terminal count, then wraps to 0.
  - No cumulative drift: frame length is exactly (10 + (PARITY!=0) + STOP_BITS-1) * CLKS_PER_BIT cycles, measured from the first tx=0 cycle to the first IDLE cycle.
- Back-to-back:
  - With tx_valid held high, a new byte is accepted on the first IDLE cycle.
  - Inter-frame gap is therefore exactly 1 cycle of tx=1 beyond the stop bits.
- tx is glitch-free: it is driven directly from a flop and changes only on bit boundaries.
- Simultaneous reset==0 and tx_valid: reset wins; nothing is accepted.

Test Plan:
1. CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1; send 0x55 -> tx = 0,1,0,1,0,1,0,1,0,1, each level exactly 4 cycles. busy=1 for 40 cycles; tx_ready returns 1 at cycle 41.
2. Same config; send 0xA3 with tx_data changed to 0xFF one cycle after acceptance -> serial LSB-first bits 1,1,0,0,0,1,0,1 (0xA3), unaffected by the change.
3. tx_valid held high with 0x00 then 0xFF -> two frames; exactly one idle tx=1 cycle after the first stop bit. tx_ready pulses high for exactly 1 cycle between frames.
4. PARITY=2, STOP_BITS=2, CLKS_PER_BIT=4; send 0x07 -> parity bit 1 (three ones, even), then tx=1 for 8 cycles; frame is 48 cycles. With PARITY=1 the parity bit is 0.
5. Reset pulled to 0 during DATA bit 3 of 0x0F -> tx=1, busy=0, tx_ready=0 at that edge. tx_ready=1 one edge after release; a new 0x81 is then sent correctly.
6. tx_valid pulsed during busy -> not accepted; exactly one frame on tx. Default CLKS_PER_BIT=434 -> bit width measured as 434 cycles.
